// File: rtl/hidden_backprop_pkg.sv
// Shared fixed-point constants, saturation rails and FSM state type for the
// hidden-layer backward pass.
package nn_fixed_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam int Z_W    = 8;

    localparam logic signed [DATA_W-1:0] SAT_POS = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_NEG = 16'sh8000;

    // Forward activation rails: a hidden output sitting on either rail has zero slope.
    localparam logic [Z_W-1:0] Z_RAIL_POS = 8'h7F;
    localparam logic [Z_W-1:0] Z_RAIL_NEG = 8'h80;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELTA = 3'd1,
        G1    = 3'd2,
        G2    = 3'd3,
        UPD   = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [DATA_W:0] v);
        logic signed [DATA_W-1:0] r;
        if (v[DATA_W] != v[DATA_W-1]) begin
            r = v[DATA_W] ? SAT_NEG : SAT_POS;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/hidden_backprop_if.sv
// Sample/handshake/weight bus between the training driver and the hidden
// backprop block.
interface hidden_backprop_if;
    import nn_fixed_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] k1;
    logic signed [DATA_W-1:0] k2;
    logic        [Z_W-1:0]    z2;
    logic signed [DATA_W-1:0] delta3;
    logic signed [DATA_W-1:0] w3;
    logic                     load;
    logic signed [DATA_W-1:0] w_load1;
    logic signed [DATA_W-1:0] w_load2;
    logic signed [DATA_W-1:0] b_load;
    logic signed [DATA_W-1:0] w2_1;
    logic signed [DATA_W-1:0] w2_2;
    logic signed [DATA_W-1:0] b2;
    logic signed [DATA_W-1:0] delta2;
    logic                     out_valid;
    logic                     busy;

    modport master (
        output in_valid, k1, k2, z2, delta3, w3, load, w_load1, w_load2, b_load,
        input  in_ready, w2_1, w2_2, b2, delta2, out_valid, busy
    );

    modport slave (
        input  in_valid, k1, k2, z2, delta3, w3, load, w_load1, w_load2, b_load,
        output in_ready, w2_1, w2_2, b2, delta2, out_valid, busy
    );

endinterface

// File: rtl/hidden_backprop_mul.sv
// q_mul_sat: Q6.10 x Q6.10 signed multiply returning Q6.10, saturating when the
// product does not fit the 16-bit result.
module q_mul_sat
    import nn_fixed_pkg::*;
(
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_p
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic        [6:0]          w_hi;

    assign w_prod = i_a * i_b;
    // Bits above the kept field plus its sign bit must all agree for the result to fit.
    assign w_hi   = w_prod[2*DATA_W-1:DATA_W+FRAC_W-1];

    // Extract the Q6.10 field or clamp to the matching rail.
    always_comb begin
        o_p = w_prod[DATA_W+FRAC_W-1:FRAC_W];
        if ((&w_hi) || (~|w_hi)) begin
            o_p = w_prod[DATA_W+FRAC_W-1:FRAC_W];
        end else begin
            o_p = w_prod[2*DATA_W-1] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/hidden_backprop.sv
// Hidden-neuron backward pass: computes delta2 and gradient-descent updates of
// w2_1/w2_2/b2 over a fixed 6-cycle sequence with one shared multiplier.
// Build option HIDDEN_BACKPROP_WSAT_EN: clamp weight updates instead of wrapping.
module hidden_backprop
    import nn_fixed_pkg::*;
#(
    parameter int                       LR_SHIFT = 4,
    parameter logic signed [DATA_W-1:0] W1_INIT  = 16'sh0000,
    parameter logic signed [DATA_W-1:0] W2_INIT  = 16'sh0000,
    parameter logic signed [DATA_W-1:0] B_INIT   = 16'sh0000
)(
    input  logic              clk,
    input  logic              reset,
    hidden_backprop_if.slave  bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [DATA_W-1:0] r_k1;
    logic signed [DATA_W-1:0] r_k2;
    logic        [Z_W-1:0]    r_z2;
    logic signed [DATA_W-1:0] r_delta3;
    logic signed [DATA_W-1:0] r_w3;
    logic signed [DATA_W-1:0] r_g1;
    logic signed [DATA_W-1:0] r_g2;
    logic signed [DATA_W-1:0] r_w1;
    logic signed [DATA_W-1:0] r_w2;
    logic signed [DATA_W-1:0] r_b;
    logic signed [DATA_W-1:0] r_delta2;
    logic                     r_out_valid;
    logic                     r_busy;

    logic                     w_accept;
    logic                     w_load_en;
    logic                     w_deriv;
    logic signed [DATA_W-1:0] w_ma;
    logic signed [DATA_W-1:0] w_mb;
    logic signed [DATA_W-1:0] w_prod;

    function automatic logic signed [DATA_W-1:0] upd(
        input logic signed [DATA_W-1:0] w,
        input logic signed [DATA_W-1:0] g
    );
        logic signed [DATA_W:0] ws;
        logic signed [DATA_W:0] gs;
        logic signed [DATA_W:0] diff;
        ws   = w;
        gs   = g;
        diff = ws - (gs >>> LR_SHIFT);
`ifdef HIDDEN_BACKPROP_WSAT_EN
        return sat_narrow(diff);
`else
        return diff[DATA_W-1:0];
`endif
    endfunction

    assign bus.in_ready  = (r_state == IDLE) & ~bus.load;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_load_en     = (r_state == IDLE) & bus.load;
    assign w_deriv       = (r_z2 != Z_RAIL_POS) && (r_z2 != Z_RAIL_NEG);

    assign bus.w2_1      = r_w1;
    assign bus.w2_2      = r_w2;
    assign bus.b2        = r_b;
    assign bus.delta2    = r_delta2;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

    // Next-state sequencing; every accepted sample walks the full chain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = DELTA;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DELTA:   w_state_nxt = G1;
            G1:      w_state_nxt = G2;
            G2:      w_state_nxt = UPD;
            UPD:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand mux for the shared multiplier.
    always_comb begin
        w_ma = r_delta3;
        w_mb = r_w3;
        case (r_state)
            DELTA: begin
                w_ma = r_delta3;
                w_mb = r_w3;
            end
            G1: begin
                w_ma = r_delta2;
                w_mb = r_k1;
            end
            G2: begin
                w_ma = r_delta2;
                w_mb = r_k2;
            end
            default: begin
                w_ma = r_delta3;
                w_mb = r_w3;
            end
        endcase
    end

    q_mul_sat u_mul (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_prod)
    );

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Sample capture, delta/gradient registers and weight storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k1     <= 16'sh0000;
            r_k2     <= 16'sh0000;
            r_z2     <= 8'h00;
            r_delta3 <= 16'sh0000;
            r_w3     <= 16'sh0000;
            r_g1     <= 16'sh0000;
            r_g2     <= 16'sh0000;
            r_delta2 <= 16'sh0000;
            r_w1     <= W1_INIT;
            r_w2     <= W2_INIT;
            r_b      <= B_INIT;
        end else begin
            if (w_accept) begin
                r_k1     <= bus.k1;
                r_k2     <= bus.k2;
                r_z2     <= bus.z2;
                r_delta3 <= bus.delta3;
                r_w3     <= bus.w3;
            end
            if (r_state == DELTA) begin
                r_delta2 <= w_deriv ? w_prod : 16'sh0000;
            end
            if (r_state == G1) begin
                r_g1 <= w_prod;
            end
            if (r_state == G2) begin
                r_g2 <= w_prod;
            end
            // Load and UPD cannot coincide: load is only honoured in IDLE.
            if (w_load_en) begin
                r_w1 <= bus.w_load1;
                r_w2 <= bus.w_load2;
                r_b  <= bus.b_load;
            end else if (r_state == UPD) begin
                r_w1 <= upd(r_w1, r_g1);
                r_w2 <= upd(r_w2, r_g2);
                r_b  <= upd(r_b, r_delta2);
            end
        end
    end

endmodule

// File: doc/hidden_backprop.md
Name: hidden_backprop

Overview:
- Backward-pass counterpart of the 2-input hidden-layer neuron in the contest neural-network datapath.
- Owns the hidden neuron's weights (w2_1, w2_2) and bias (b2), and feeds them to the forward neuron.
- On each accepted training sample it takes the output-layer error and computes the hidden delta, then gradient-descent-updates the weights and bias.
- One shared 16x16 multiplier is sequenced by an FSM; latency is fixed.

Parameters:
- LR_SHIFT, 4: learning rate as a power of two; step = gradient >>> LR_SHIFT (arithmetic).
- W1_INIT, 16'sh0000: reset value of w2_1.
- W2_INIT, 16'sh0000: reset value of w2_2.
- B_INIT, 16'sh0000: reset value of b2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  training sample is present.
- in_ready  out  1  block can accept a sample.
- k1, k2  in  16  signed Q6.10; forward inputs of the sample.
- z2  in  8  signed Q4.4; forward hidden output of the sample.
- delta3  in  16  signed Q6.10; output-layer error.
- w3  in  16  signed Q6.10; output-layer weight attached to this neuron.
- load  in  1  load external weights.
- w_load1, w_load2, b_load  in  16  signed Q6.10; values for load.
- w2_1, w2_2, b2  out  16  signed Q6.10; current weights and bias (registered).
- delta2  out  16  signed Q6.10; hidden delta of the last sample.
- out_valid  out  1  one-cycle pulse: update complete.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (reset==0 at an edge):
  - w2_1=W1_INIT, w2_2=W2_INIT, b2=B_INIT.
  - delta2=0, out_valid=0, FSM=IDLE.
  - Any operation in progress is aborted with no out_valid.
- Handshake:
  - in_ready = (state==IDLE) & ~load.
  - A sample is accepted on an edge where in_valid & in_ready; all inputs are captured into registers at that edge.
- Load:
  - Honoured only in IDLE; weights take w_load1, w_load2, b_load at that edge.
  - Ignored when busy.
  - load and in_valid in the same IDLE cycle: load wins and the sample is not accepted.
- FSM: IDLE -> DELTA -> G1 -> G2 -> UPD -> DONE -> IDLE.
  - out_valid is high in DONE only. Accept edge to out_valid = 5 cycles; one sample per 6 cycles.
- Multiplier rule (qmul):
  - Form the 32-bit signed product and take bits [25:10].
  - If bits [31:25] are not all equal, saturate to 0x7FFF (positive) or 0x8000 (negative).
- DELTA:
  - deriv = 0 if z2==8'h7F or z2==8'h80 (forward rail saturated), else 1.
  - delta2 <= deriv ? qmul(delta3,w3) : 0.
  - The sequence still runs to DONE when delta2 = 0 (fixed latency).
- G1: g1 <= qmul(delta2,k1).
- G2: g2 <= qmul(delta2,k2).
- gb = delta2.
- UPD:
  - w2_1 <= upd(w2_1,g1); w2_2 <= upd(w2_2,g2); b2 <= upd(b2,gb).
  - upd(w,g) = w - (g >>> LR_SHIFT), computed 17-bit signed, then narrowed per the optional feature.
- Outputs are stable between updates and loads.
- w2_1, w2_2 and b2 change only at the UPD edge, a load edge or a reset edge.
- delta2 changes only at the DELTA edge or a reset edge.

Optional Feature:
- Macro: HIDDEN_BACKPROP_WSAT_EN.
- Defined: a 17-bit update result outside 16-bit range clamps to 0x7FFF or 0x8000.
- Undefined: keep the low 16 bits (two's-complement wrap).

Decomposition:
- Package nn_fixed_pkg holds:
  - constants DATA_W=16, FRAC_W=10, Z_W=8;
  - saturation rails;
  - state typedef for the FSM (IDLE, DELTA, G1, G2, UPD, DONE).
- Sub-module q_mul_sat: 16x16 signed multiply, [25:10] extraction and saturation. Instantiated once and operand-muxed by state.

Test Plan:
- Nominal update:
  - Setup: LR_SHIFT=4; load w2_1=0x0400, w2_2=0x0200, b2=0x0000.
  - Stimulus: k1=0x0400, k2=0x0800, z2=0x10, delta3=0x0400, w3=0x0200.
  - Required: delta2=0x0200; w2_1=0x03E0, w2_2=0x01C0, b2=0xFFE0; out_valid exactly 5 cycles after accept.
- Derivative gate: same stimulus with z2=0x7F (then 0x80) -> delta2=0, weights unchanged, out_valid still at cycle 5.
- Weight overflow:
  - Setup: w2_1=0x7FF0.
  - Stimulus: delta3=0x8000, w3=0x0400, k1=0x0400, z2=0x10 -> step -0x0800.
  - Required: w2_1=0x7FFF with the macro, 0x87F0 without.
- Product saturation: delta3=0x7FFF, w3=0x7FFF, z2=0x10 -> delta2=0x7FFF.
- Reset mid-operation:
  - Stimulus: reset=0 for one edge while in G1.
  - Required: weights = INIT values, delta2=0, no out_valid pulse, in_ready=1 the cycle after release.
- Load/valid contention:
  - Stimulus: load=1 and in_valid=1 in the same IDLE cycle.
  - Required: loaded values appear, in_ready=0 that cycle, no update; the sample is accepted the next cycle if still valid.
